block_mover: RTL

Active-piece controller for the Tetris datapath. It is the producer side of the board-controller handshake: it consumes `gen_flag` and the settled board, and supplies `block`, `bottom_flag` and `top_flag`. On each `gen_flag` it spawns a pseudo-random tetromino, applies gravity and lateral moves with collision checks against the board, and reports landing or spawn overflow. It sits between the input debouncers and the board controller.

---
 rtl/block_mover.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/block_mover.sv
// block_mover: active-piece controller for the Tetris datapath.
//
// Spawns a pseudo-random tetromino on gen_flag, applies gravity and lateral
// moves with collision checks against the settled board, and reports landing
// (bottom_flag pulse) or spawn overflow (sticky top_flag).
//
// Parameters:
//   TICK_DIV   Clk cycles per gravity step
//   SPAWN_COL  anchor column for spawning
// Ports:
//   Clk, Reset     clock (rising edge), synchronous active-high reset
//   gen_flag       one-cycle spawn request, honoured only in IDLE
//   board[119:0]   settled cells, cell (r,c) is bit r*10+c, row 11 on top
//   btn_left/right debounced level inputs, acted on at rising edges
//   btn_drop       hard-drop level input (only with HARD_DROP_EN)
//   block[31:0]    four squares, square k at [31-8(k-1) -: 8] = {row, col}
//   bottom_flag    one-cycle landing pulse
//   top_flag       sticky spawn-collision flag
//   piece_id[2:0]  shape of the current piece, 1..7
//
// Optional feature: define HARD_DROP_EN to add btn_drop and hard-drop mode.
module block_mover #(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned SPAWN_COL = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         gen_flag,
  input  logic [119:0] board,
  input  logic         btn_left,
  input  logic         btn_right,
`ifdef HARD_DROP_EN
  input  logic         btn_drop,
`endif
  output logic [31:0]  block,
  output logic         bottom_flag,
  output logic         top_flag,
  output logic [2:0]   piece_id
);

  typedef enum logic [2:0] {StIdle, StSpawn, StFall, StLand, StLost} state_e;

  state_e            state_q;
  logic [2:0]        lfsr_q;
  logic [31:0]       tick_cnt_q;
  logic              pending_q;
  logic              left_q;
  logic              right_q;

  logic              left_edge, right_edge, lat_left, lat_right, tick;
  logic              drop_start, drop_active;
  logic              mv_lat, mv_down;
  logic signed [4:0] move_dr, move_dc;
  logic signed [4:0] cand_row [4];
  logic signed [4:0] cand_col [4];
  logic [31:0]       cand_block;
  logic              cand_ok;

  // Spawn position of a shape: offsets (drow, dcol) from anchor (10, SPAWN_COL).
  function automatic logic [31:0] spawn_block(input logic [2:0] id);
    logic [3:0]  up;  // drow per square, square 1 in bit 3
    int          dc [4];
    logic [31:0] blk;
    up = 4'b0000;
    dc = '{0, 0, 0, 0};
    case (id)
      3'd1:    begin up = 4'b1111; dc = '{-1, 0, 1,  2}; end
      3'd2:    begin up = 4'b1100; dc = '{ 0, 1, 0,  1}; end
      3'd3:    begin up = 4'b1110; dc = '{-1, 0, 1,  0}; end
      3'd4:    begin up = 4'b1100; dc = '{ 0, 1, -1, 0}; end
      3'd5:    begin up = 4'b1100; dc = '{-1, 0, 0,  1}; end
      3'd6:    begin up = 4'b1110; dc = '{-1, 0, 1, -1}; end
      3'd7:    begin up = 4'b1110; dc = '{-1, 0, 1,  1}; end
      default: ;
    endcase
    blk = '0;
    for (int k = 0; k < 4; k++) begin
      blk[31-8*k -: 4] = 4'(10 + (up[3-k] ? 1 : 0));
      blk[27-8*k -: 4] = 4'(int'(SPAWN_COL) + dc[k]);
    end
    return blk;
  endfunction

  // True when (r, c) lies on the board and is not occupied.
  function automatic logic cell_free(input logic signed [4:0] r,
                                     input logic signed [4:0] c,
                                     input logic [119:0]      brd);
    logic [6:0] idx;
    if (r < 5'sd0 || r > 5'sd11 || c < 5'sd0 || c > 5'sd9) return 1'b0;
    idx = 7'(r[3:0]) * 7'd10 + 7'(c[3:0]);
    return !brd[idx];
  endfunction

`ifdef HARD_DROP_EN
  logic drop_q;
  logic drop_mode_q;

  assign drop_start  = (state_q == StFall) && btn_drop && !drop_q && !drop_mode_q;
  assign drop_active = drop_mode_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      drop_q      <= 1'b0;
      drop_mode_q <= 1'b0;
    end else begin
      drop_q <= btn_drop;
      if (state_q != StFall) drop_mode_q <= 1'b0;
      else if (drop_start)   drop_mode_q <= 1'b1;
    end
  end
`else
  assign drop_start  = 1'b0;
  assign drop_active = 1'b0;
`endif

  assign left_edge  = btn_left & ~left_q;
  assign right_edge = btn_right & ~right_q;
  // Simultaneous edges cancel each other.
  assign lat_left   = left_edge & ~right_edge;
  assign lat_right  = right_edge & ~left_edge;
  assign tick       = (tick_cnt_q == TICK_DIV - 1);

  // Move selection: drop mode, then lateral, then pending/new gravity.
  always_comb begin
    mv_lat  = 1'b0;
    mv_down = 1'b0;
    if (state_q == StFall && !drop_start) begin
      if (drop_active)                mv_down = 1'b1;
      else if (lat_left || lat_right) mv_lat  = 1'b1;
      else                            mv_down = pending_q | tick;
    end
    move_dr = mv_down ? -5'sd1 : 5'sd0;
    move_dc = !mv_lat ? 5'sd0 : (lat_left ? -5'sd1 : 5'sd1);
  end

  // Candidate position; with a zero move this is the spawn-collision check.
  always_comb begin
    cand_ok    = 1'b1;
    cand_block = '0;
    for (int k = 0; k < 4; k++) begin
      cand_row[k] = $signed({1'b0, block[31-8*k -: 4]}) + move_dr;
      cand_col[k] = $signed({1'b0, block[27-8*k -: 4]}) + move_dc;
      cand_block[31-8*k -: 8] = {cand_row[k][3:0], cand_col[k][3:0]};
      if (!cell_free(cand_row[k], cand_col[k], board)) cand_ok = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      block       <= '0;
      piece_id    <= '0;
      bottom_flag <= 1'b0;
      top_flag    <= 1'b0;
      lfsr_q      <= 3'b001;
      tick_cnt_q  <= '0;
      pending_q   <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
    end else begin
      left_q      <= btn_left;
      right_q     <= btn_right;
      bottom_flag <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gen_flag) begin
            block    <= spawn_block(lfsr_q);
            piece_id <= lfsr_q;
            lfsr_q   <= {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
            state_q  <= StSpawn;
          end
        end
        StSpawn: begin
          if (!cand_ok) begin
            top_flag <= 1'b1;
            state_q  <= StLost;
          end else begin
            tick_cnt_q <= '0;
            pending_q  <= 1'b0;
            state_q    <= StFall;
          end
        end
        StFall: begin
          tick_cnt_q <= tick ? '0 : tick_cnt_q + 32'd1;
          if (mv_lat) begin
            if (tick)    pending_q <= 1'b1;
            if (cand_ok) block     <= cand_block;
          end else if (mv_down) begin
            pending_q <= 1'b0;
            if (cand_ok) block   <= cand_block;
            else         state_q <= StLand;
          end
        end
        StLand: begin
          bottom_flag <= 1'b1;
          state_q     <= StIdle;
        end
        StLost: top_flag <= 1'b1;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
